note_event_gen: RTL and testbench

//  Inverse of the mono note tracker: converts a level-style mono voice (note + gate)

---
 rtl/note_event_gen.sv | 114 +++++++++++
 tb/tb_note_event_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/note_event_gen.sv
// rtl/note_event_gen.sv - mono note/gate level to note_on/note_off event stream
module note_event_gen #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] in_note,
    input  logic       in_gate,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic       ev_on,
    output logic [6:0] ev_note,
    output logic       overflow
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          prev_gate;
    logic [6:0]    prev_note;

    logic [1:0]    need;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic [AW:0]   free;
    logic          drop;
    logic [1:0]    writes;
    logic          pop;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr_nx;
    logic [AW:0]   count_nx;
    logic [7:0]    head_nx;

    assign ev_valid = (count != '0);

    // Classify this edge as rise, fall, legato or nothing and build the entries to push
    always_comb begin
        need = 2'd0;
        d0   = 8'd0;
        d1   = 8'd0;
        if (!prev_gate && in_gate) begin
            need = 2'd1;
            d0   = {1'b1, in_note};
        end else if (prev_gate && !in_gate) begin
            need = 2'd1;
            d0   = {1'b0, prev_note};
        end else if (prev_gate && in_gate && (in_note != prev_note)) begin
            need = 2'd2;
            d0   = {1'b0, prev_note};
            d1   = {1'b1, in_note};
        end
    end

    // FIFO bookkeeping; room is judged before the pop so an OFF/ON pair is never split
    always_comb begin
        free      = DEPTH_W - count;
        drop      = ((AW+1)'(need) > free);
        writes    = drop ? 2'd0 : need;
        pop       = (count != '0) && ev_ready;
        wr_ptr_p1 = wr_ptr + AW'(1);
        rd_ptr_nx = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        count_nx  = count + (AW+1)'(writes) - (AW+1)'(pop);
        head_nx   = {ev_on, ev_note};
        if (count_nx != '0) begin
            if ((writes != 2'd0) && (rd_ptr_nx == wr_ptr)) begin
                head_nx = d0;
            end else if ((writes == 2'd2) && (rd_ptr_nx == wr_ptr_p1)) begin
                head_nx = d1;
            end else begin
                head_nx = mem[rd_ptr_nx];
            end
        end
    end

    // Event storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (rst && (writes != 2'd0)) begin
            mem[wr_ptr] <= d0;
        end
        if (rst && (writes == 2'd2)) begin
            mem[wr_ptr_p1] <= d1;
        end
    end

    // Tracker, pointers, sticky overflow and registered head entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_gate <= 1'b0;
            prev_note <= 7'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            ev_on     <= 1'b0;
            ev_note   <= 7'd0;
        end else begin
            prev_gate <= in_gate;
            prev_note <= in_note;
            wr_ptr    <= wr_ptr + AW'(writes);
            rd_ptr    <= rd_ptr_nx;
            count     <= count_nx;
            if (drop) begin
                overflow <= 1'b1;
            end
            ev_on     <= head_nx[7];
            ev_note   <= head_nx[6:0];
        end
    end

endmodule

// File: tb/tb_note_event_gen.sv
// tb/tb_note_event_gen.sv - self-checking bench for note_event_gen
module tb_note_event_gen;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [6:0] in_note;
    logic       in_gate;
    logic       ev_ready;
    logic       ev_valid;
    logic       ev_on;
    logic [6:0] ev_note;
    logic       overflow;

    int tests;
    int fails;

    note_event_gen #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_note  (in_note),
        .in_gate  (in_gate),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {on,note} events plus the last shown head
    logic [7:0] mq[$];
    logic       m_pg;
    logic [6:0] m_pn;
    logic       m_ovf;
    logic [7:0] m_last;

    initial begin
        mq = {};
        m_pg = 0; m_pn = 0; m_ovf = 0; m_last = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq = {};
                m_pg = 0; m_pn = 0; m_ovf = 0; m_last = 0;
            end else begin
                automatic logic [7:0] evs[$] = {};
                automatic bit do_pop = (mq.size() != 0) && ev_ready;
                automatic int room = DEPTH - mq.size();
                if (!m_pg && in_gate) evs.push_back({1'b1, in_note});
                else if (m_pg && !in_gate) evs.push_back({1'b0, m_pn});
                else if (m_pg && in_gate && in_note != m_pn) begin
                    evs.push_back({1'b0, m_pn});
                    evs.push_back({1'b1, in_note});
                end
                if (do_pop) void'(mq.pop_front());
                if (evs.size() > room) m_ovf = 1;
                else foreach (evs[i]) mq.push_back(evs[i]);
                m_pg = in_gate;
                m_pn = in_note;
                if (mq.size() != 0) m_last = mq[0];
            end
        end
    end

    // Compare DUT against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_valid", ev_valid, mq.size() != 0);
            chk("cmp_on", ev_on, m_last[7]);
            chk("cmp_note", ev_note, m_last[6:0]);
            chk("cmp_overflow", overflow, m_ovf);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic head(input string name, input int v, input int on, input int note);
        chk({name, "_valid"}, ev_valid, v);
        if (v != 0) begin
            chk({name, "_on"}, ev_on, on);
            chk({name, "_note"}, ev_note, note);
        end
    endtask

    initial begin
        logic [7:0] exp4 [4];
        tests = 0;
        fails = 0;
        rst = 1'b0; in_gate = 1'b0; in_note = 7'd60; ev_ready = 1'b1;
        cyc(2);
        chk("rst_valid", ev_valid, 0);
        chk("rst_note", ev_note, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        cyc(1);

        // 1: rise
        in_gate = 1'b1;
        cyc(1);
        head("t1_on60", 1, 1, 60);
        cyc(1);
        head("t1_empty", 0, 0, 0);

        // 2: legato 60->64
        in_note = 7'd64;
        cyc(1);
        head("t2_off60", 1, 0, 60);
        cyc(1);
        head("t2_on64", 1, 1, 64);
        cyc(1);
        head("t2_empty", 0, 0, 0);

        // 3: fall with note changed in the same cycle
        in_gate = 1'b0; in_note = 7'd10;
        cyc(1);
        head("t3_off64", 1, 0, 64);
        cyc(1);
        head("t3_empty", 0, 0, 0);

        // 4: stalled legato run overflows, then drains in order
        in_gate = 1'b1; in_note = 7'd60;
        cyc(3);
        ev_ready = 1'b0;
        in_note = 7'd62; cyc(1);
        in_note = 7'd64; cyc(1);
        in_note = 7'd65; cyc(1);
        chk("t4_overflow", overflow, 1);
        exp4[0] = {1'b0, 7'd60};
        exp4[1] = {1'b1, 7'd62};
        exp4[2] = {1'b0, 7'd62};
        exp4[3] = {1'b1, 7'd64};
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head($sformatf("t4_drain%0d", i), 1, exp4[i][7], exp4[i][6:0]);
            cyc(1);
        end
        head("t4_empty", 0, 0, 0);

        // 5: random back-pressure during a burst of note activity
        for (int i = 0; i < 60; i++) begin
            ev_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) in_gate = ~in_gate;
            in_note = 7'(60 + $urandom_range(0, 3));
            cyc(1);
        end

        // 6: reset while three events are queued
        in_gate = 1'b0; ev_ready = 1'b1;
        cyc(8);
        in_gate = 1'b1; in_note = 7'd60;
        cyc(3);
        ev_ready = 1'b0;
        in_note = 7'd62; cyc(1);
        in_gate = 1'b0; cyc(1);
        head("t6_queued", 1, 0, 60);
        chk("t6_ovf_before", overflow, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", ev_valid, 0);
        chk("t6_rst_overflow", overflow, 0);
        chk("t6_rst_note", ev_note, 0);
        cyc(1);
        rst = 1'b1; ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("t6_post%0d_valid", i), ev_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
